borrow_lookahead_sub_pipe: RTL



---
 rtl/borrow_lookahead_sub_pipe_pkg.sv | 24 ++
 rtl/borrow_logic_nib.sv | 54 +++++
 rtl/borrow_lookahead_sub_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/borrow_lookahead_sub_pipe_pkg.sv
// Shared types for the pipelined borrow-lookahead subtractor.
// Stage bundles and the registered result layout live here.
package sub_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NIB_DEF   = 4;

  typedef logic [NIB_DEF-1:0] nib_t;

  typedef struct packed {
    nib_t diff_lo;
    logic br_mid;
    nib_t a_hi;
    nib_t b_hi;
  } s1_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] diff;
    logic                 borrow_out;
    logic                 overflow;
    logic                 zero;
  } res_t;

endpackage

// File: rtl/borrow_logic_nib.sv
// One lookahead group: difference bits plus flattened borrows.
// Every borrow is a two-level sum of products over g, p and br_in.
module borrow_logic_nib #(
  parameter int NIB = 4
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           br_in,
  output logic [NIB-1:0] d,
  output logic           br_out,
  output logic           gg,
  output logic           gp
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   br;
  logic [NIB:0]   gsum;
  logic           prod;
  logic           term;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  // Expand each borrow into independent product terms, no ripple.
  always_comb begin
    br   = '0;
    gsum = '0;
    prod = 1'b0;
    term = 1'b0;
    br[0] = br_in;
    for (int i = 0; i < NIB; i++) begin
      prod = br_in;
      for (int j = 0; j <= i; j++) begin
        prod = prod & p[j];
      end
      gsum[i+1] = 1'b0;
      for (int k = 0; k <= i; k++) begin
        term = g[k];
        for (int j = k + 1; j <= i; j++) begin
          term = term & p[j];
        end
        gsum[i+1] = gsum[i+1] | term;
      end
      br[i+1] = gsum[i+1] | prod;
    end
  end

  assign d      = a ^ b ^ br[NIB-1:0];
  assign gg     = gsum[NIB];
  assign gp     = &p;
  assign br_out = br[NIB];

endmodule

// File: rtl/borrow_lookahead_sub_pipe.sv
// Two-stage 8-bit subtractor D = A - B - Bin with valid/ready.
// Low group resolves in stage 1, high group and flags in stage 2.
module borrow_lookahead_sub_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NIB   = NIB_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  s1_t  s1_q, s1_d;
  res_t res_q, res_d;
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv, s2_adv;

  logic [NIB-1:0] d_lo, d_hi;
  logic           br_mid;
  logic           lo_gg, lo_gp;
  logic           hi_br, hi_gg, hi_gp;
  logic           unused_lo;
  logic           unused_hi;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  borrow_logic_nib #(.NIB(NIB)) u_lo (
    .a      (a[NIB-1:0]),
    .b      (b[NIB-1:0]),
    .br_in  (bin),
    .d      (d_lo),
    .br_out (br_mid),
    .gg     (lo_gg),
    .gp     (lo_gp)
  );

  assign unused_lo = lo_gg ^ lo_gp;

  borrow_logic_nib #(.NIB(NIB)) u_hi (
    .a      (s1_q.a_hi),
    .b      (s1_q.b_hi),
    .br_in  (s1_q.br_mid),
    .d      (d_hi),
    .br_out (hi_br),
    .gg     (hi_gg),
    .gp     (hi_gp)
  );

  assign unused_hi = hi_br;

  // Stage 1 bundle: low difference, mid borrow, upper operands.
  always_comb begin
    s1_d         = s1_q;
    s1_d.diff_lo = d_lo;
    s1_d.br_mid  = br_mid;
    s1_d.a_hi    = a[WIDTH-1:NIB];
    s1_d.b_hi    = b[WIDTH-1:NIB];
  end

  // Stage 2 result: full difference and flags from the high group.
  always_comb begin
    res_d            = res_q;
    res_d.diff       = {d_hi, s1_q.diff_lo};
    res_d.borrow_out = hi_gg | (hi_gp & s1_q.br_mid);
    res_d.overflow   = (s1_q.a_hi[NIB-1] != s1_q.b_hi[NIB-1])
                     && (d_hi[NIB-1] != s1_q.a_hi[NIB-1]);
    res_d.zero       = ~|{d_hi, s1_q.diff_lo};
  end

  // Stage 1 register: loads when it can hand its content onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2 register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign diff       = res_q.diff;
  assign borrow_out = res_q.borrow_out;
  assign overflow   = res_q.overflow;
  assign zero       = res_q.zero;

endmodule
